mem_stage_lsu: RTL

- Memory-stage load/store unit plus MEM/WB pipeline register for the 5-stage RV32I core.
- Consumes the EX/MEM register outputs and drives the data-memory bus using a req/gnt/rvalid handshake.
- Performs byte/half/word lane steering and load extension, and registers results into the W stage.
- Asserts StallM to freeze the upstream IF–EX stages and the EX/MEM register while a memory access is outstanding.

---
 rtl/mem_stage_lsu_pkg.sv | 15 +
 rtl/mem_stage_lsu_if.sv | 15 +
 rtl/mem_stage_lsu_lane_align.sv | 44 ++++
 rtl/mem_stage_lsu.sv | 132 +++++++++++++
 4 files changed

// File: rtl/mem_stage_lsu_pkg.sv
// Shared encodings for the memory stage: ResultSrc, Funct3 access sizes and LSU FSM states.
// Pure definitions, no logic.
package core_pkg;
  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, REQ, RESP} lsu_state_t;
endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus, req/gnt/rvalid handshake: master (LSU) holds request fields until DGnt,
// slave returns one DRValid per granted load.
interface mem_stage_lsu_if;
  logic [31:0] DAddr;
  logic        DReq;
  logic        DWe;
  logic [3:0]  DBe;
  logic [31:0] DWData;
  logic        DGnt;
  logic        DRValid;
  logic [31:0] DRData;

  modport master (output DAddr, DReq, DWe, DBe, DWData, input DGnt, DRValid, DRData);
  modport slave  (input DAddr, DReq, DWe, DBe, DWData, output DGnt, DRValid, DRData);
endinterface

// File: rtl/mem_stage_lsu_lane_align.sv
// Byte/half lane steering for stores and lane extract plus sign/zero extension for loads.
// Purely combinational, no latency, no backpressure.
module mem_lane_align
  import core_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    case (addr_lo)
      2'd0:    rbyte = rdata[7:0];
      2'd1:    rbyte = rdata[15:8];
      2'd2:    rbyte = rdata[23:16];
      default: rbyte = rdata[31:24];
    endcase
    rhalf = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Undefined encodings fall through to word behaviour.
    be         = 4'b1111;
    wdata_lane = wdata;
    rdata_ext  = rdata;
    case (funct3)
      F3_B, F3_BU: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = (funct3 == F3_B) ? {{24{rbyte[7]}}, rbyte} : {24'b0, rbyte};
      end
      F3_H, F3_HU: begin
        be         = 4'b0011 << addr_lo;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = (funct3 == F3_H) ? {{16{rhalf[15]}}, rhalf} : {16'b0, rhalf};
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// M-stage LSU and MEM/WB register: 1 cycle for non-memory ops, stores 1+grant wait, loads >= 2.
// StallM freezes upstream while a request waits for DGnt or a load waits for DRValid.
module mem_stage_lsu
  import core_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_W      = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [1:0]      ResultSrcM,
  input  logic            RegWriteM,
  input  logic            MemWriteM,
  input  logic [2:0]      Funct3M,
  input  logic [31:0]     ALUResultM,
  input  logic [31:0]     WriteDataM,
  input  logic [4:0]      RdM,
  input  logic [31:0]     PCPlus4M,
  mem_stage_lsu_if.master dbus,
  output logic            StallM,
  output logic            MisalignM,
  output logic            BusErrM,
  output logic [1:0]      ResultSrcW,
  output logic            RegWriteW,
  output logic [31:0]     ALUResultW,
  output logic [31:0]     ReadDataW,
  output logic [4:0]      RdW,
  output logic [31:0]     PCPlus4W
);
  localparam logic [TIMEOUT_W-1:0] TMAX = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

  lsu_state_t           state;
  logic [TIMEOUT_W-1:0] tcnt;
  logic                 is_store, access, misaligned, mis_pulse, ld_done;
  logic                 req, stall, timeout;
  logic [3:0]           be;
  logic [31:0]          wd_lane, rd_ext;

  mem_lane_align u_align (
    .funct3    (Funct3M),
    .addr_lo   (ALUResultM[1:0]),
    .wdata     (WriteDataM),
    .rdata     (dbus.DRData),
    .be        (be),
    .wdata_lane(wd_lane),
    .rdata_ext (rd_ext)
  );

  assign is_store   = MemWriteM;
  assign access     = (ResultSrcM == RES_MEM) || is_store;
  // Funct3[1:0]: 00 byte, 01 half, 1x word (covers the undefined encodings too).
  assign misaligned = access && ((Funct3M[1:0] == 2'b01 && ALUResultM[0]) ||
                                 (Funct3M[1] && ALUResultM[1:0] != 2'b00));
  assign mis_pulse  = (state == IDLE) && misaligned;
  assign ld_done    = (state == RESP) && dbus.DRValid;

  always_comb begin
    req     = 1'b0;
    stall   = 1'b0;
    timeout = 1'b0;
    case (state)
      IDLE: begin
        req   = access && !misaligned;
        stall = req && !(is_store && dbus.DGnt);
      end
      REQ: begin
        req     = 1'b1;
        timeout = !dbus.DGnt && (tcnt == TMAX);
        stall   = !(dbus.DGnt && is_store) && !timeout;
      end
      RESP: begin
        timeout = !dbus.DRValid && (tcnt == TMAX);
        stall   = !dbus.DRValid && !timeout;
      end
      default: ;
    endcase
  end

  assign dbus.DAddr  = {ALUResultM[31:2], 2'b00};
  assign dbus.DReq   = reset && req;
  assign dbus.DWe    = reset && req && is_store;
  assign dbus.DBe    = (reset && req) ? be : 4'b0000;
  assign dbus.DWData = wd_lane;
  assign StallM      = reset && stall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      tcnt       <= '0;
      MisalignM  <= 1'b0;
      BusErrM    <= 1'b0;
      ResultSrcW <= RES_ALU;
      RegWriteW  <= 1'b0;
      ALUResultW <= 32'b0;
      ReadDataW  <= 32'b0;
      RdW        <= 5'b0;
      PCPlus4W   <= 32'b0;
    end else begin
      MisalignM <= mis_pulse;
      BusErrM   <= timeout;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (req) state <= dbus.DGnt ? (is_store ? IDLE : RESP) : REQ;
        end
        REQ: begin
          tcnt <= tcnt + 1'b1;
          if (dbus.DGnt)   state <= is_store ? IDLE : RESP;
          else if (timeout) state <= IDLE;
        end
        RESP: begin
          tcnt <= tcnt + 1'b1;
          if (dbus.DRValid || timeout) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // Stalled, misaligned and timed-out cycles retire a bubble; other W fields hold.
      if (stall || mis_pulse || timeout) begin
        RegWriteW  <= 1'b0;
        ResultSrcW <= RES_ALU;
      end else begin
        RegWriteW  <= RegWriteM;
        ResultSrcW <= ResultSrcM;
        ALUResultW <= ALUResultM;
        RdW        <= RdM;
        PCPlus4W   <= PCPlus4M;
        if (ld_done) ReadDataW <= rd_ext;
      end
    end
  end
endmodule
